// File: rtl/button_pkg.sv
// Shared event codes and FSM state encoding for the button decoder.
// Latency: none (declarations only).
// Backpressure: n/a. The WAIT2 state exists only when BUTTON_DOUBLE_EN is defined.
package button_pkg;

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
`ifdef BUTTON_DOUBLE_EN
        ,
        ST_WAIT2
`endif
    } state_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes the raw active-low button and debounces it into a clean pressed level.
// Latency: a clean raw edge reaches btn_level exactly 2 + DEBOUNCE_CYC cycles later.
// Backpressure: none; free-running level output.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    // Inverting at the input keeps the reset value of the chain (0) equal to
    // "released", so reset never produces a spurious pressed sample.
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer, then count consecutive disagreeing samples;
    // a single agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            sync1 <= ~btn_n;
            sync2 <= sync1;
            if (sync2 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_level <= ~btn_level;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_decoder.sv
// Classifies debounced button presses into SHORT / LONG (and DOUBLE with BUTTON_DOUBLE_EN) events.
// Latency: ev_valid rises the cycle after the classifying FSM transition (release, LONG_CYC hold, or second press).
// Backpressure: single-entry event register; a new event arriving while one is held unaccepted is dropped and ev_drop pulses.
module button_decoder
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100,
    parameter int LONG_CYC     = 10000,
    parameter int DOUBLE_CYC   = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       btn_level,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ready,
    output logic       ev_drop
);

    localparam int HOLD_MAX = (LONG_CYC > DOUBLE_CYC) ? LONG_CYC : DOUBLE_CYC;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_MAX);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
`ifdef BUTTON_DOUBLE_EN
    localparam logic [HW-1:0] DBL_LAST  = HW'(DOUBLE_CYC - 1);
`endif

    state_t        state;
    state_t        state_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic          level_q;
    logic          rise;
    logic          fall;
    logic [1:0]    ev_new;

    button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .btn_level(btn_level)
    );

    assign rise = btn_level & ~level_q;
    assign fall = ~btn_level & level_q;

    // State, hold counter and previous debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            level_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            level_q  <= btn_level;
        end
    end

    // Press classification; the hold counter saturates instead of wrapping.
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        ev_new   = EV_NONE;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nx = ST_PRESSED;
                    hold_nx  = '0;
                end
            end
            ST_PRESSED: begin
                if (hold_cnt != HOLD_TOP) begin
                    hold_nx = hold_cnt + 1'b1;
                end
                // A release wins over the long threshold in the same cycle:
                // the button is no longer pressed.
                if (fall) begin
`ifdef BUTTON_DOUBLE_EN
                    state_nx = ST_WAIT2;
                    hold_nx  = '0;
`else
                    ev_new   = EV_SHORT;
                    state_nx = ST_IDLE;
`endif
                end else if (hold_cnt == LONG_LAST) begin
                    ev_new   = EV_LONG;
                    state_nx = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_nx = ST_IDLE;
                end
            end
`ifdef BUTTON_DOUBLE_EN
            ST_WAIT2: begin
                if (hold_cnt != HOLD_TOP) begin
                    hold_nx = hold_cnt + 1'b1;
                end
                // A second press arriving on the timeout cycle still counts as a double.
                if (rise) begin
                    ev_new   = EV_DOUBLE;
                    state_nx = ST_HELD;
                end else if (hold_cnt == DBL_LAST) begin
                    ev_new   = EV_SHORT;
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                hold_nx  = '0;
            end
        endcase
    end

    // Single-entry event register: load when empty or being drained, else drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_code  <= EV_NONE;
            ev_drop  <= 1'b0;
        end else begin
            ev_drop <= 1'b0;
            if (ev_new != EV_NONE) begin
                if (!ev_valid || ev_ready) begin
                    ev_valid <= 1'b1;
                    ev_code  <= ev_new;
                end else begin
                    ev_drop <= 1'b1;
                end
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_decoder.sv
// Directed bench for button_decoder with a timestamp-based reference model.
// Inputs change 1 time unit after each rising edge; outputs are compared on falling edges.
// Expected behaviour follows BUTTON_DOUBLE_EN when it is defined for the build.
module tb_button_decoder;

    localparam int D  = 4;
    localparam int L  = 20;
    localparam int DB = 10;

    localparam int P_IDLE  = 0;
    localparam int P_PRESS = 1;
    localparam int P_HELD  = 2;
    localparam int P_WAIT  = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_n    = 1'b1;
    logic       ev_ready = 1'b1;
    logic       btn_level;
    logic       ev_valid;
    logic       ev_drop;
    logic [1:0] ev_code;

    int total = 0;
    int bad   = 0;

    // Handshake / observation counters maintained by the compare process.
    int n_short  = 0;
    int n_long   = 0;
    int n_double = 0;
    int n_drop   = 0;
    int n_lvl_hi = 0;

    always #5 clk = ~clk;

    button_decoder #(
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (L),
        .DOUBLE_CYC  (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .btn_level(btn_level),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ready (ev_ready),
        .ev_drop  (ev_drop)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Level: toggles when the D most recent synchronized samples (2-cycle old
    // and older) all disagree with it. Events: derived from the edge times of
    // the level (press start / release) and fixed thresholds.
    logic m_lvl     = 1'b0;
    logic m_smp [0:D];
    logic m_rise_pd = 1'b0;
    logic m_fall_pd = 1'b0;
    int   m_phase   = P_IDLE;
    int   m_mark    = 0;
    int   cyc       = 0;
    logic m_vld     = 1'b0;
    int   m_code    = 0;
    logic m_drop    = 1'b0;
    logic model_on  = 1'b0;

    task automatic model_step();
        logic rise_now;
        logic fall_now;
        logic all_diff;
        int   ev;
        cyc++;
        if (rst) begin
            m_lvl     = 1'b0;
            for (int i = 0; i <= D; i++) m_smp[i] = 1'b0;
            m_rise_pd = 1'b0;
            m_fall_pd = 1'b0;
            m_phase   = P_IDLE;
            m_vld     = 1'b0;
            m_code    = 0;
            m_drop    = 1'b0;
            return;
        end
        rise_now  = m_rise_pd;
        fall_now  = m_fall_pd;
        m_rise_pd = 1'b0;
        m_fall_pd = 1'b0;

        all_diff = 1'b1;
        for (int i = 1; i <= D; i++) if (m_smp[i] == m_lvl) all_diff = 1'b0;
        if (all_diff) begin
            m_lvl     = ~m_lvl;
            m_rise_pd = m_lvl;
            m_fall_pd = ~m_lvl;
        end
        for (int i = D; i >= 1; i--) m_smp[i] = m_smp[i-1];
        m_smp[0] = ~btn_n;

        ev = 0;
        case (m_phase)
            P_IDLE: if (rise_now) begin m_phase = P_PRESS; m_mark = cyc - 1; end
            P_PRESS: begin
                if (fall_now) begin
`ifdef BUTTON_DOUBLE_EN
                    m_phase = P_WAIT;
                    m_mark  = cyc - 1;
`else
                    ev      = 1;
                    m_phase = P_IDLE;
`endif
                end else if (cyc == m_mark + 1 + L) begin
                    ev      = 2;
                    m_phase = P_HELD;
                end
            end
            P_HELD: if (fall_now) m_phase = P_IDLE;
            default: begin
                if (rise_now) begin
                    ev      = 3;
                    m_phase = P_HELD;
                end else if (cyc == m_mark + 1 + DB) begin
                    ev      = 1;
                    m_phase = P_IDLE;
                end
            end
        endcase

        m_drop = 1'b0;
        if (ev != 0) begin
            if (!m_vld || ev_ready) begin
                m_vld  = 1'b1;
                m_code = ev;
            end else begin
                m_drop = 1'b1;
            end
        end else if (m_vld && ev_ready) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i <= D; i++) m_smp[i] = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
            model_on = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("level", btn_level, m_lvl);
                chk("valid", ev_valid, m_vld);
                chk("drop", ev_drop, m_drop);
                if (m_vld) chk("code", ev_code, m_code);
            end
            if (btn_level) n_lvl_hi++;
            if (ev_drop) n_drop++;
            if (ev_valid && ev_ready) begin
                if (ev_code == 2'b01) n_short++;
                else if (ev_code == 2'b10) n_long++;
                else if (ev_code == 2'b11) n_double++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold current inputs n cycles; report the first cycle (1-based) at which
    // btn_level and ev_valid were seen high, 0 if never.
    task automatic hold(input int n, output int fl, output int fv);
        fl = 0;
        fv = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (fl == 0 && btn_level) fl = i;
            if (fv == 0 && ev_valid) fv = i;
        end
    endtask

    initial begin
        int fl, fv, s0, l0, d0, dr0, h0;

        // Reset
        rst = 1'b1;
        step(2);
        chk("rst_level", btn_level, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_drop", ev_drop, 0);
        rst = 1'b0;
        step(5);

        // Bounce: 2-cycle toggles never satisfy a 4-cycle debounce
        h0 = n_lvl_hi; s0 = n_short; l0 = n_long; d0 = n_double;
        for (int i = 0; i < 6; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        btn_n = 1'b1;
        step(20);
        chk("bounce_level_hi", n_lvl_hi - h0, 0);
        chk("bounce_events", (n_short - s0) + (n_long - l0) + (n_double - d0), 0);

        // Short press
        s0 = n_short; l0 = n_long;
        btn_n = 1'b0;
        hold(10, fl, fv);
        chk("short_level_delay", fl, 6);
        btn_n = 1'b1;
        hold(40, fl, fv);
`ifdef BUTTON_DOUBLE_EN
        chk("short_event_delay", fv, 17);
`else
        chk("short_event_delay", fv, 7);
`endif
        chk("short_count", n_short - s0, 1);
        chk("short_no_long", n_long - l0, 0);

        // Long press
        s0 = n_short; l0 = n_long;
        btn_n = 1'b0;
        hold(40, fl, fv);
        chk("long_event_delay", fv, 27);
        btn_n = 1'b1;
        hold(40, fl, fv);
        chk("long_release_quiet", fv, 0);
        chk("long_count", n_long - l0, 1);
        chk("long_no_short", n_short - s0, 0);

        // Backpressure: short then long with ev_ready low
        ev_ready = 1'b0;
        dr0 = n_drop;
        btn_n = 1'b0; step(10);
        btn_n = 1'b1; step(30);
        btn_n = 1'b0; step(40);
        btn_n = 1'b1; step(20);
        chk("bp_valid_held", ev_valid, 1);
        chk("bp_code_held", ev_code, 1);
        chk("bp_drop_count", n_drop - dr0, 1);
        ev_ready = 1'b1;
        step(1);
        chk("bp_valid_cleared", ev_valid, 0);
        step(10);

        // Reset at hold count 15 of a press
        s0 = n_short; l0 = n_long;
        btn_n = 1'b0;
        step(22);
        rst = 1'b1;
        step(1);
        chk("midrst_level", btn_level, 0);
        chk("midrst_valid", ev_valid, 0);
        chk("midrst_code", ev_code, 0);
        chk("midrst_drop", ev_drop, 0);
        rst = 1'b0;
        hold(60, fl, fv);
        chk("midrst_redetect", fl, 6);
        chk("midrst_long_delay", fv, 27);
        btn_n = 1'b1;
        step(40);
        chk("midrst_long_count", n_long - l0, 1);
        chk("midrst_no_short", n_short - s0, 0);

        // Double press: 8 low, 5 high, 8 low
        s0 = n_short; l0 = n_long; d0 = n_double;
        btn_n = 1'b0; step(8);
        btn_n = 1'b1; step(5);
        btn_n = 1'b0;
        hold(8, fl, fv);
        btn_n = 1'b1;
        step(40);
`ifdef BUTTON_DOUBLE_EN
        chk("dbl_event_delay", fv, 7);
        chk("dbl_count", n_double - d0, 1);
        chk("dbl_no_short", n_short - s0, 0);
`else
        chk("dbl_event_delay", fv, 2);
        chk("dbl_never_double", n_double - d0, 0);
        chk("dbl_two_shorts", n_short - s0, 2);
`endif
        chk("dbl_no_long", n_long - l0, 0);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
